// File: rtl/bcd_disp_scan.sv
// Two-digit multiplexed 7-segment driver for packed BCD values.
// Accepted values wait in a one-entry buffer and are committed only at a frame boundary.
module bcd_disp_scan #(
    parameter int SCAN_DIV = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] bcd_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             digit;
    logic [7:0]       disp;
    logic [7:0]       pend;
    logic             pend_valid;
    logic [3:0]       nib;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h79;
        endcase
    endfunction

    assign in_ready = !pend_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            digit      <= 1'b0;
            disp       <= 8'h00;
            pend       <= 8'h00;
            pend_valid <= 1'b0;
        end else begin
            if (div == DIV_MAX) begin
                div   <= '0;
                digit <= ~digit;
                // Frame boundary: swap in the pending value so a frame never mixes two values
                if (digit && pend_valid) begin
                    disp       <= pend;
                    pend_valid <= 1'b0;
                end
            end else begin
                div <= div + 1'b1;
            end
            if (in_valid && in_ready) begin
                pend       <= bcd_in;
                pend_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        nib = digit ? disp[7:4] : disp[3:0];
        an  = digit ? 2'b10 : 2'b01;
        seg = seg7(nib);
        if (BLANK_LZ && digit && (disp[7:4] == 4'd0))
            seg = 7'h00;
    end

    assign err = (disp[7:4] > 4'd9) || (disp[3:0] > 4'd9);

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Bench for bcd_disp_scan: cycle model with a pending-value queue plus directed scenario checks.
// Three instances cover SCAN_DIV=4/BLANK_LZ=1, SCAN_DIV=4/BLANK_LZ=0 and SCAN_DIV=1.
module tb_bcd_disp_scan;

    localparam int SD_A = 4;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] bcd_in = 8'h00;
    logic       in_valid_c = 1'b0;
    logic [7:0] bcd_c = 8'h00;

    logic       rdy_a, rdy_b, rdy_c;
    logic [6:0] seg_a, seg_b, seg_c;
    logic [1:0] an_a, an_b, an_c;
    logic       err_a, err_b, err_c;

    int n_chk = 0;
    int n_err = 0;

    // model of instance a
    int         m_cyc = 0;
    logic [7:0] m_disp = 8'h00;
    logic [7:0] exp_q [$];
    bit         started = 1'b0;

    bcd_disp_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
        .bcd_in(bcd_in), .seg(seg_a), .an(an_a), .err(err_a));

    bcd_disp_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
        .bcd_in(bcd_in), .seg(seg_b), .an(an_b), .err(err_b));

    bcd_disp_scan #(.SCAN_DIV(1), .BLANK_LZ(1'b1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(rdy_c),
        .bcd_in(bcd_c), .seg(seg_c), .an(an_c), .err(err_c));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard update: values accepted by the handshake queue up, one pops per frame end
    always @(posedge clk) begin : mdl
        bit rdy;
        if (rst) begin
            started = 1'b1;
            m_cyc   = 0;
            m_disp  = 8'h00;
            exp_q.delete();
        end else begin
            rdy = (exp_q.size() == 0);
            if ((m_cyc % (2 * SD_A)) == (2 * SD_A - 1) && exp_q.size() > 0)
                m_disp = exp_q.pop_front();
            if (in_valid && rdy)
                exp_q.push_back(bcd_in);
            m_cyc++;
        end
    end

    always @(negedge clk) begin : mon
        bit         d;
        logic [3:0] nib;
        logic [6:0] es;
        if (started) begin
            d   = ((m_cyc / SD_A) % 2) == 1;
            nib = d ? m_disp[7:4] : m_disp[3:0];
            es  = (d && m_disp[7:4] == 4'd0) ? 7'h00 : SEG_TAB[nib];
            chk("mdl_an",  32'(an_a),  d ? 32'd2 : 32'd1);
            chk("mdl_seg", 32'(seg_a), 32'(es));
            chk("mdl_err", 32'(err_a), 32'((m_disp[7:4] > 4'd9) || (m_disp[3:0] > 4'd9)));
            chk("mdl_rdy", 32'(rdy_a), 32'(exp_q.size() == 0));
        end
    end

    initial begin
        // reset and idle scan
        do_reset();
        chk("rst_an",  32'(an_a),  32'h1);
        chk("rst_seg", 32'(seg_a), 32'h3F);
        chk("rst_err", 32'(err_a), 32'h0);
        chk("rst_rdy", 32'(rdy_a), 32'h1);
        tick(4);
        chk("idle_tens_an",  32'(an_a),  32'h2);
        chk("idle_tens_seg", 32'(seg_a), 32'h00);
        chk("idle_tens_segb", 32'(seg_b), 32'h3F);
        tick(12);

        // commit timing
        do_reset();
        tick();
        in_valid = 1'b1; bcd_in = 8'h42;
        tick();
        in_valid = 1'b0;
        chk("cm_rdy_low", 32'(rdy_a), 32'h0);
        tick(5);
        chk("cm_hold_seg", 32'(seg_a), 32'h00);
        tick();
        chk("cm_units_an",  32'(an_a),  32'h1);
        chk("cm_units_seg", 32'(seg_a), 32'h5B);
        chk("cm_rdy_back",  32'(rdy_a), 32'h1);
        tick(4);
        chk("cm_tens_an",  32'(an_a),  32'h2);
        chk("cm_tens_seg", 32'(seg_a), 32'h66);
        tick(4);

        // backpressure: 13 held from cycle 2, taken once the buffer frees
        do_reset();
        tick();
        in_valid = 1'b1; bcd_in = 8'h42;
        tick();
        bcd_in = 8'h13;
        tick(6);
        chk("bp_rdy_c8", 32'(rdy_a), 32'h1);
        chk("bp_seg_c8", 32'(seg_a), 32'h5B);
        tick();
        in_valid = 1'b0;
        chk("bp_rdy_c9", 32'(rdy_a), 32'h0);
        tick(3);
        chk("bp_tens42", 32'(seg_a), 32'h66);
        tick(4);
        chk("bp_units13", 32'(seg_a), 32'h4F);
        tick(4);
        chk("bp_tens13", 32'(seg_a), 32'h06);
        tick(4);

        // blanking and error flag
        do_reset();
        tick();
        in_valid = 1'b1; bcd_in = 8'h07;
        tick();
        in_valid = 1'b0;
        tick(6);
        chk("bl_units_seg", 32'(seg_a), 32'h07);
        tick(4);
        chk("bl_tens_blank", 32'(seg_a), 32'h00);
        chk("bl_tens_noblank", 32'(seg_b), 32'h3F);
        in_valid = 1'b1; bcd_in = 8'h3A;
        tick();
        in_valid = 1'b0;
        chk("er_err_before", 32'(err_a), 32'h0);
        tick(3);
        chk("er_units_e", 32'(seg_a), 32'h79);
        chk("er_err_a", 32'(err_a), 32'h1);
        chk("er_err_b", 32'(err_b), 32'h1);
        tick(4);
        chk("er_tens_seg", 32'(seg_a), 32'h4F);
        in_valid = 1'b1; bcd_in = 8'h21;
        tick();
        in_valid = 1'b0;
        tick(2);
        chk("er_err_hold", 32'(err_a), 32'h1);
        tick();
        chk("er_err_clear", 32'(err_a), 32'h0);
        chk("er_units_1", 32'(seg_a), 32'h06);
        tick(4);

        // reset while a value is pending
        do_reset();
        tick();
        in_valid = 1'b1; bcd_in = 8'h99;
        tick();
        in_valid = 1'b0;
        tick(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_an",  32'(an_a),  32'h1);
        chk("mr_seg", 32'(seg_a), 32'h3F);
        chk("mr_rdy", 32'(rdy_a), 32'h1);
        tick(8);
        chk("mr_no99", 32'(seg_a), 32'h3F);
        tick(8);

        // SCAN_DIV=1 instance
        do_reset();
        chk("s1_an0", 32'(an_c), 32'h1);
        tick();
        chk("s1_an1", 32'(an_c), 32'h2);
        in_valid_c = 1'b1; bcd_c = 8'h58;
        tick();
        in_valid_c = 1'b0;
        chk("s1_rdy_low", 32'(rdy_c), 32'h0);
        tick(2);
        for (int i = 0; i < 4; i++) begin
            chk("s1_an",  32'(an_c),  (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("s1_seg", 32'(seg_c), (i % 2 == 0) ? 32'h7F : 32'h6D);
            tick();
        end
        chk("s1_rdy", 32'(rdy_c), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
